axi_lite_slv_mem: RTL and testbench

AXI_LITE_SLV_MEM -- requirements
Module: axi_lite_slv_mem

---
 rtl/axi_lite_slv_mem.sv | 214 +++++++++++++++++++++
 tb/tb_axi_lite_slv_mem.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_slv_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axi_lite_slv_mem                                             |
// | Description : AXI4-Lite slave backed by a word-addressed memory. Serves a  |
// |               single transaction at a time; writes take priority over      |
// |               reads. AW and W may arrive in any order.                     |
// | Ports       : aclk, aresetn (async, active-low)                            |
// |               s_axi_aw*  write address channel (awprot ignored)            |
// |               s_axi_w*   write data channel, byte strobes                  |
// |               s_axi_b*   write response channel                            |
// |               s_axi_ar*  read address channel (arprot ignored)             |
// |               s_axi_r*   read data channel                                 |
// | Option      : define AXI_LITE_SLV_MEM_DECERR_EN to answer out-of-range     |
// |               word indices with DECERR; otherwise indices wrap.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module axi_lite_slv_mem #(
  parameter int ADDR_W = 12,   // byte address width
  parameter int DATA_W = 32,   // only 32 is supported
  parameter int DEPTH  = 256   // words, power of two, >= 2, <= 2**(ADDR_W-2)
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [ADDR_W-1:0]     s_axi_awaddr,
  input  logic [2:0]            s_axi_awprot,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_W-1:0]     s_axi_wdata,
  input  logic [DATA_W/8-1:0]   s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_W-1:0]     s_axi_araddr,
  input  logic [2:0]            s_axi_arprot,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [DATA_W-1:0]     s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);

  localparam int         c_IDX_W       = $clog2(DEPTH);
  localparam int         c_NB          = DATA_W / 8;
  localparam logic [1:0] c_RESP_OKAY   = 2'b00;
  localparam logic [1:0] c_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BRESP = 2'd1,
    RDATA = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                r_init;
  logic                r_aw_held;
  logic                r_w_held;
  logic [ADDR_W-1:0]   r_awaddr;
  logic [DATA_W-1:0]   r_wdata;
  logic [c_NB-1:0]     r_wstrb;
  logic [1:0]          r_bresp;
  logic [1:0]          r_rresp;
  logic [DATA_W-1:0]   r_rdata;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_idle;
  logic                w_aw_hs;
  logic                w_w_hs;
  logic                w_ar_hs;
  logic                w_b_hs;
  logic                w_wr_go;
  logic                w_rd_go;
  logic [ADDR_W-1:0]   w_wr_addr;
  logic [DATA_W-1:0]   w_wr_data;
  logic [c_NB-1:0]     w_wr_strb;
  logic [ADDR_W-3:0]   w_wr_idx_full;
  logic [ADDR_W-3:0]   w_rd_idx_full;
  logic [c_IDX_W-1:0]  w_wr_idx;
  logic [c_IDX_W-1:0]  w_rd_idx;
  logic                w_wr_oor;
  logic                w_rd_oor;
  logic                w_unused;

  // r_init stays low for the first cycle after reset release so that no
  // handshake can land on the very first edge.
  assign w_idle        = (r_state == IDLE);
  assign s_axi_awready = w_idle && r_init && !r_aw_held;
  assign s_axi_wready  = w_idle && r_init && !r_w_held;
  // Any pending or offered write blocks the read channel (write priority).
  assign s_axi_arready = w_idle && r_init && !r_aw_held && !r_w_held &&
                         !s_axi_awvalid && !s_axi_wvalid;

  assign w_aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_w_hs  = s_axi_wvalid  && s_axi_wready;
  assign w_ar_hs = s_axi_arvalid && s_axi_arready;
  assign w_b_hs  = s_axi_bvalid  && s_axi_bready;

  // Write operands come from the holding registers when that half arrived
  // earlier, otherwise straight from the bus on the completing edge.
  assign w_wr_addr     = r_aw_held ? r_awaddr : s_axi_awaddr;
  assign w_wr_data     = r_w_held  ? r_wdata  : s_axi_wdata;
  assign w_wr_strb     = r_w_held  ? r_wstrb  : s_axi_wstrb;
  assign w_wr_idx_full = w_wr_addr[ADDR_W-1:2];
  assign w_rd_idx_full = s_axi_araddr[ADDR_W-1:2];
  assign w_wr_idx      = w_wr_idx_full[c_IDX_W-1:0];
  assign w_rd_idx      = w_rd_idx_full[c_IDX_W-1:0];

`ifdef AXI_LITE_SLV_MEM_DECERR_EN
  // Extra top bit keeps the compare valid when DEPTH == 2**(ADDR_W-2).
  localparam logic [ADDR_W-2:0] c_DEPTH_X = (ADDR_W-1)'(DEPTH);
  assign w_wr_oor = ({1'b0, w_wr_idx_full} >= c_DEPTH_X);
  assign w_rd_oor = ({1'b0, w_rd_idx_full} >= c_DEPTH_X);
`else
  assign w_wr_oor = 1'b0;
  assign w_rd_oor = 1'b0;
`endif

  assign w_unused = ^{s_axi_awprot, s_axi_arprot, w_wr_addr[1:0],
                      s_axi_araddr[1:0], w_wr_idx_full, w_rd_idx_full};

  assign s_axi_bvalid = (r_state == BRESP);
  assign s_axi_rvalid = (r_state == RDATA);
  assign s_axi_bresp  = r_bresp;
  assign s_axi_rresp  = r_rresp;
  assign s_axi_rdata  = r_rdata;

  // State register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_wr_go     = 1'b0;
    w_rd_go     = 1'b0;
    case (r_state)
      IDLE: begin
        if ((r_aw_held || w_aw_hs) && (r_w_held || w_w_hs)) begin
          w_wr_go     = 1'b1;
          w_state_nxt = BRESP;
        end else if (w_ar_hs) begin
          w_rd_go     = 1'b1;
          w_state_nxt = RDATA;
        end
      end
      BRESP:   if (s_axi_bready) w_state_nxt = IDLE;
      RDATA:   if (s_axi_rready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Holding registers and response payloads
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_init    <= 1'b0;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bresp   <= c_RESP_OKAY;
      r_rresp   <= c_RESP_OKAY;
      r_rdata   <= '0;
    end else begin
      r_init <= 1'b1;
      if (w_wr_go) begin
        // Both halves count as held until the response is taken.
        r_aw_held <= 1'b1;
        r_w_held  <= 1'b1;
        r_bresp   <= w_wr_oor ? c_RESP_DECERR : c_RESP_OKAY;
      end else if (w_b_hs) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
      end else begin
        if (w_aw_hs) begin
          r_aw_held <= 1'b1;
          r_awaddr  <= s_axi_awaddr;
        end
        if (w_w_hs) begin
          r_w_held <= 1'b1;
          r_wdata  <= s_axi_wdata;
          r_wstrb  <= s_axi_wstrb;
        end
      end
      if (w_rd_go) begin
        r_rdata <= w_rd_oor ? '0 : r_mem[w_rd_idx];
        r_rresp <= w_rd_oor ? c_RESP_DECERR : c_RESP_OKAY;
      end
    end
  end

  // Storage is deliberately not reset so contents survive aresetn. A reset
  // pulse clears r_init, which kills w_wr_go before the next edge.
  always_ff @(posedge aclk) begin
    if (w_wr_go && !w_wr_oor) begin
      for (int i = 0; i < c_NB; i++) begin
        if (w_wr_strb[i]) begin
          r_mem[w_wr_idx][8*i +: 8] <= w_wr_data[8*i +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_slv_mem.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_axi_lite_slv_mem                                          |
// | Description : Directed bench for axi_lite_slv_mem with a transaction-level |
// |               reference model checked on every falling clock edge.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_axi_lite_slv_mem;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 256;

  logic        aclk    = 1'b0;
  logic        aresetn = 1'b0;
  logic [11:0] awaddr  = '0;
  logic [11:0] araddr  = '0;
  logic [2:0]  awprot  = '0;
  logic [2:0]  arprot  = '0;
  logic        awvalid = 1'b0;
  logic        wvalid  = 1'b0;
  logic        arvalid = 1'b0;
  logic        bready  = 1'b0;
  logic        rready  = 1'b0;
  logic [31:0] wdata   = '0;
  logic [3:0]  wstrb   = '0;
  logic        awready, wready, arready, bvalid, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int n_tests = 0;
  int n_fail  = 0;

  axi_lite_slv_mem #(.ADDR_W(ADDR_W), .DATA_W(32), .DEPTH(DEPTH)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axi_awaddr  (awaddr),
    .s_axi_awprot  (awprot),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arprot  (arprot),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic [31:0] m_mem [DEPTH];
  logic [11:0] aw_q [$];
  logic [35:0] w_q  [$];          // {data, strb}
  bit          eb_v, er_v, m_init, busy, x_aw, x_w, x_ar;
  logic [1:0]  eb_resp, er_resp;
  logic [31:0] er_data;
  logic [11:0] pa;
  logic [35:0] pw;

  function automatic bit oor(input logic [11:0] a);
`ifdef AXI_LITE_SLV_MEM_DECERR_EN
    return int'(a >> 2) >= DEPTH;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int widx(input logic [11:0] a);
    return int'(a >> 2) % DEPTH;
  endfunction

  always @(negedge aclk) begin
    if (!aresetn) begin
      aw_q.delete();
      w_q.delete();
      eb_v   = 1'b0;
      er_v   = 1'b0;
      m_init = 1'b0;
      check("rst_valids",  32'({bvalid, rvalid}), 32'd0);
      check("rst_readies", 32'({awready, wready, arready}), 32'd0);
      check("rst_resps",   32'({bresp, rresp}), 32'd0);
      check("rst_rdata",   rdata, 32'd0);
    end else begin
      busy = eb_v || er_v;
      x_aw = m_init && !busy && (aw_q.size() == 0);
      x_w  = m_init && !busy && (w_q.size() == 0);
      x_ar = m_init && !busy && (aw_q.size() == 0) && (w_q.size() == 0) && !awvalid && !wvalid;
      check("awready", 32'(awready), 32'(x_aw));
      check("wready",  32'(wready),  32'(x_w));
      check("arready", 32'(arready), 32'(x_ar));
      check("bvalid",  32'(bvalid),  32'(eb_v));
      check("rvalid",  32'(rvalid),  32'(er_v));
      if (eb_v) check("bresp", 32'(bresp), 32'(eb_resp));
      if (er_v) begin
        check("rresp", 32'(rresp), 32'(er_resp));
        check("rdata", rdata, er_data);
      end
      // predict the state after the coming rising edge
      if (eb_v) begin
        if (bready) eb_v = 1'b0;
      end else if (er_v) begin
        if (rready) er_v = 1'b0;
      end else begin
        if (awvalid && x_aw) aw_q.push_back(awaddr);
        if (wvalid && x_w)   w_q.push_back({wdata, wstrb});
        if (aw_q.size() != 0 && w_q.size() != 0) begin
          pa = aw_q.pop_front();
          pw = w_q.pop_front();
          eb_v = 1'b1;
          if (oor(pa)) begin
            eb_resp = 2'b11;
          end else begin
            eb_resp = 2'b00;
            for (int i = 0; i < 4; i++)
              if (pw[i]) m_mem[widx(pa)][8*i +: 8] = pw[4 + 8*i +: 8];
          end
        end else if (arvalid && x_ar) begin
          er_v    = 1'b1;
          er_resp = oor(araddr) ? 2'b11 : 2'b00;
          er_data = oor(araddr) ? 32'd0 : m_mem[widx(araddr)];
        end
      end
      m_init = 1'b1;
    end
  end

  // ---------------- driver tasks (all start/end at posedge + 1) ----------------
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly);
    bit aw_done = 1'b0;
    bit w_done  = 1'b0;
    int n = 0;
    while (!(aw_done && w_done) && n < 50) begin
      awaddr  = a;
      wdata   = d;
      wstrb   = s;
      awvalid = !aw_done && (n >= aw_dly);
      wvalid  = !w_done && (n >= w_dly);
      @(negedge aclk);
      if (awvalid && awready) aw_done = 1'b1;
      if (wvalid && wready)   w_done  = 1'b1;
      step();
      n++;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    check("write_accept_timeout", 32'(aw_done && w_done), 32'd1);
  endtask

  task automatic axi_read(input logic [11:0] a);
    bit done = 1'b0;
    int n = 0;
    while (!done && n < 50) begin
      araddr  = a;
      arvalid = 1'b1;
      @(negedge aclk);
      if (arready) done = 1'b1;
      step();
      n++;
    end
    arvalid = 1'b0;
    check("read_accept_timeout", 32'(done), 32'd1);
  endtask

  task automatic get_b(input int stall, output logic [1:0] resp, output time t);
    int seen = 0;
    int n = 0;
    bit done = 1'b0;
    resp = 2'bxx;
    t = 0;
    while (!done && n < 50) begin
      bready = (seen >= stall);
      @(negedge aclk);
      if (bvalid) begin
        if (bready) begin
          resp = bresp;
          t    = $time;
          done = 1'b1;
        end
        seen++;
      end
      step();
      n++;
    end
    bready = 1'b0;
    check("bresp_timeout", 32'(done), 32'd1);
  endtask

  task automatic get_r(input int stall, output logic [31:0] data, output logic [1:0] resp,
                       output time t);
    int seen = 0;
    int n = 0;
    bit done = 1'b0;
    data = 'x;
    resp = 2'bxx;
    t = 0;
    while (!done && n < 50) begin
      rready = (seen >= stall);
      @(negedge aclk);
      if (rvalid) begin
        if (rready) begin
          data = rdata;
          resp = rresp;
          t    = $time;
          done = 1'b1;
        end
        seen++;
      end
      step();
      n++;
    end
    rready = 1'b0;
    check("rdata_timeout", 32'(done), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [1:0]  br, rr, br2;
    logic [31:0] rd;
    time         tb_t, tr_t, tb2_t;

    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(negedge aclk);
    check("init_cycle_awready", 32'(awready), 32'd0);
    check("init_cycle_wready",  32'(wready),  32'd0);
    step();
    @(negedge aclk);
    check("second_cycle_awready", 32'(awready), 32'd1);
    check("second_cycle_wready",  32'(wready),  32'd1);
    step();

    // AW and W on the same edge, bready high -> bvalid next cycle
    bready = 1'b1;
    axi_write(12'h010, 32'hDEADBEEF, 4'hF, 0, 0);
    @(negedge aclk);
    check("same_edge_bvalid_next", 32'(bvalid), 32'd1);
    check("same_edge_bresp", 32'(bresp), 32'd0);
    step();
    bready = 1'b0;
    axi_read(12'h010);
    get_r(0, rd, rr, tr_t);
    check("rd_010_data", rd, 32'hDEADBEEF);
    check("rd_010_resp", 32'(rr), 32'd0);

    // W first, AW three cycles later, lower two byte lanes only
    axi_write(12'h010, 32'h0000CAFE, 4'h3, 3, 0);
    get_b(0, br, tb_t);
    check("w_first_bresp", 32'(br), 32'd0);
    axi_read(12'h013);          // unaligned: same word
    get_r(0, rd, rr, tr_t);
    check("w_first_readback", rd, 32'hDEADCAFE);

    // zero strobe leaves the word untouched
    axi_write(12'h010, 32'h12121212, 4'h0, 0, 0);
    get_b(0, br, tb_t);
    check("zero_strb_bresp", 32'(br), 32'd0);
    axi_read(12'h010);
    get_r(0, rd, rr, tr_t);
    check("zero_strb_readback", rd, 32'hDEADCAFE);

    // AR and AW/W offered together at 0x020 -> write served first
    fork
      begin
        axi_write(12'h020, 32'h5A5A1234, 4'hF, 0, 0);
        get_b(0, br, tb_t);
      end
      begin
        axi_read(12'h020);
        get_r(0, rd, rr, tr_t);
      end
    join
    check("collide_bresp", 32'(br), 32'd0);
    check("collide_read_new_data", rd, 32'h5A5A1234);
    check("collide_write_first", 32'(tb_t < tr_t), 32'd1);

    // back-pressure: B and R held for five cycles while other requests wait
    axi_write(12'h050, 32'h0BADF00D, 4'hF, 0, 0);
    fork
      get_b(5, br, tb_t);
      axi_read(12'h050);
    join
    check("stall_bresp", 32'(br), 32'd0);
    fork
      get_r(5, rd, rr, tr_t);
      axi_write(12'h060, 32'hFEEDFACE, 4'hF, 0, 0);
    join
    check("stall_rdata", rd, 32'h0BADF00D);
    check("stall_rresp", 32'(rr), 32'd0);
    get_b(0, br2, tb2_t);
    check("after_stall_bresp", 32'(br2), 32'd0);
    check("after_stall_order", 32'(tr_t < tb2_t), 32'd1);

    // out-of-range index 0x100 (byte 0x400)
    axi_write(12'h000, 32'h11111111, 4'hF, 0, 0);
    get_b(0, br, tb_t);
    axi_write(12'h400, 32'h22222222, 4'hF, 0, 0);
    get_b(0, br, tb_t);
`ifdef AXI_LITE_SLV_MEM_DECERR_EN
    check("oor_bresp_decerr", 32'(br), 32'd3);
    axi_read(12'h400);
    get_r(0, rd, rr, tr_t);
    check("oor_rresp_decerr", 32'(rr), 32'd3);
    check("oor_rdata_zero", rd, 32'd0);
    axi_read(12'h000);
    get_r(0, rd, rr, tr_t);
    check("oor_word0_kept", rd, 32'h11111111);
`else
    check("oor_bresp_okay", 32'(br), 32'd0);
    axi_read(12'h000);
    get_r(0, rd, rr, tr_t);
    check("oor_word0_aliased", rd, 32'h22222222);
    check("oor_rresp_okay", 32'(rr), 32'd0);
`endif

    // reset while a write response is pending
    axi_write(12'h030, 32'h12345678, 4'hF, 0, 0);
    get_b(0, br, tb_t);
    axi_write(12'h040, 32'hA5A5A5A5, 4'hF, 0, 0);
    @(negedge aclk);
    check("pre_reset_bvalid", 32'(bvalid), 32'd1);
    @(posedge aclk);
    #1 aresetn = 1'b0;
    #1 check("reset_drops_bvalid", 32'(bvalid), 32'd0);
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(negedge aclk);
    check("post_reset_awready_low", 32'(awready), 32'd0);
    check("post_reset_arready_low", 32'(arready), 32'd0);
    step();
    @(negedge aclk);
    check("post_reset_awready_high", 32'(awready), 32'd1);
    step();
    axi_read(12'h030);
    get_r(0, rd, rr, tr_t);
    check("retained_030", rd, 32'h12345678);
    axi_read(12'h040);
    get_r(0, rd, rr, tr_t);
    check("retained_040", rd, 32'hA5A5A5A5);
    axi_read(12'h010);
    get_r(0, rd, rr, tr_t);
    check("retained_010", rd, 32'hDEADCAFE);

    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
